// File: rtl/sd_block_reader_pkg.sv
// sd_block_reader_pkg: shared constants and the state encoding for the CMD17
// block reader.
package sd_block_reader_pkg;

  // READ_SINGLE_BLOCK command index
  localparam logic [6:0] CMD17 = 7'd17;

  // Data start token and the idle filler byte the card sends before it
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] TOKEN_IDLE  = 8'hFF;

  // err_code values reported alongside done
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_R1    = 2'd1;
  localparam logic [1:0] ERR_TOKEN = 2'd2;
  localparam logic [1:0] ERR_CRC   = 2'd3;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_R1    = 3'd2,
    ST_WAIT_TOKEN = 3'd3,
    ST_DATA       = 3'd4,
    ST_CRC        = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

endpackage

// File: rtl/sd_block_reader_if.sv
// sd_block_reader_if: command/data bus between the block reader (master) and
// the SD SPI command controller (slave).
interface sd_block_reader_if;
  logic [6:0]  sd_cmd;
  logic [31:0] sd_address;
  logic        sd_en;
  logic        sd_rdy;
  logic        sd_valid_status;
  logic [6:0]  sd_resp_status;
  logic [7:0]  sd_data;
  logic        sd_data_valid;

  modport master (
    output sd_cmd, sd_address, sd_en,
    input  sd_rdy, sd_valid_status, sd_resp_status, sd_data, sd_data_valid
  );

  modport slave (
    input  sd_cmd, sd_address, sd_en,
    output sd_rdy, sd_valid_status, sd_resp_status, sd_data, sd_data_valid
  );
endinterface

// File: rtl/sd_block_reader_crc16.sv
// sd_block_reader_crc16: byte-serial CRC16-CCITT (x^16+x^12+x^5+1, init 0),
// bits taken MSB first. clear has priority over en.
module sd_block_reader_crc16
  import sd_block_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Accumulate one byte per enable; restart on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= '0;
    end else if (clear) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc_step(crc_q, data);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_block_reader.sv
// sd_block_reader: sequences one CMD17 single-block read on the SD SPI
// command controller: issue, R1 check, start-token hunt, data stream, CRC.
// Optional feature macro SD_BLOCK_CRC_EN: check the received block CRC16 and
// report err_code 3 on mismatch; without it the CRC bytes are discarded.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// req_lba must be stable on that cycle. rd_valid has no ready: the consumer
// takes every byte on the cycle it is presented.
module sd_block_reader
  import sd_block_reader_pkg::*;
#(
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int BYTE_ADDR      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_lba,
  output logic        req_ready,
  sd_block_reader_if.master sd,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [6:0]  r1_status,
  output state_t      dbg_state
);

  localparam int CW = $clog2(BLOCK_BYTES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state, state_nxt;
  logic [31:0]    addr_q;
  logic [TW-1:0]  timer_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     err_code_q;
  logic [6:0]     r1_q;
  logic [7:0]     rd_data_q;
  logic           rd_valid_q;
  logic           rd_last_q;
  logic           accept;
  logic           waiting;
  logic           timer_last;
  logic           data_byte;
  logic           last_data;
  logic           crc_bad;

  assign accept     = (state == ST_IDLE) && req_valid && sd.sd_rdy;
  assign waiting    = (state == ST_WAIT_R1) || (state == ST_WAIT_TOKEN);
  assign timer_last = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign data_byte  = (state == ST_DATA) && sd.sd_data_valid;
  assign last_data  = (cnt_q == CW'(BLOCK_BYTES - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT_R1;
      ST_WAIT_R1: begin
        if (sd.sd_valid_status) begin
          state_nxt = (sd.sd_resp_status == 7'd0) ? ST_WAIT_TOKEN : ST_DONE;
        end else if (timer_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_WAIT_TOKEN: begin
        // 0xFF filler keeps waiting but does not stop the timer
        if (sd.sd_data_valid && sd.sd_data != TOKEN_IDLE) begin
          state_nxt = (sd.sd_data == TOKEN_START) ? ST_DATA : ST_DONE;
        end else if (timer_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DATA: if (sd.sd_data_valid && last_data) state_nxt = ST_CRC;
      ST_CRC:  if (sd.sd_data_valid && cnt_q == CW'(BLOCK_BYTES + 1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy      = (state != ST_IDLE);
    req_ready = (state == ST_IDLE) && sd.sd_rdy;
    sd.sd_en  = (state == ST_ISSUE);
    sd.sd_cmd = busy ? CMD17 : 7'd0;
    done      = (state == ST_DONE);
    err       = done && (err_code_q != ERR_NONE);
  end

  // Address latch, wait timer, byte counter, R1 capture and error code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      err_code_q <= ERR_NONE;
      r1_q       <= '0;
    end else begin
      if (accept) begin
        addr_q     <= (BYTE_ADDR != 0) ? (req_lba << 9) : req_lba;
        cnt_q      <= '0;
        err_code_q <= ERR_NONE;
      end else if ((state == ST_DATA || state == ST_CRC) && sd.sd_data_valid) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Timer restarts on every state change, so each wait gets a fresh budget
      timer_q <= (waiting && state_nxt == state) ? timer_q + 1'b1 : '0;
      if (state == ST_WAIT_R1 && sd.sd_valid_status) r1_q <= sd.sd_resp_status;
      if (state_nxt == ST_DONE) begin
        case (state)
          ST_WAIT_R1:    err_code_q <= sd.sd_valid_status ? ERR_R1 : ERR_TOKEN;
          ST_WAIT_TOKEN: err_code_q <= ERR_TOKEN;
          ST_CRC:        if (crc_bad) err_code_q <= ERR_CRC;
          default:       ;
        endcase
      end
    end
  end

  // Registered data stream toward the consumer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= data_byte;
      rd_last_q  <= data_byte && last_data;
      if (data_byte) rd_data_q <= sd.sd_data;
    end
  end

`ifdef SD_BLOCK_CRC_EN
  logic [15:0] crc_calc;
  logic [7:0]  crc_hi_q;

  sd_block_reader_crc16 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (data_byte),
    .data  (sd.sd_data),
    .crc   (crc_calc)
  );

  // Hold the received CRC high byte until the low byte arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_hi_q <= '0;
    else if (state == ST_CRC && sd.sd_data_valid && cnt_q == CW'(BLOCK_BYTES)) crc_hi_q <= sd.sd_data;
  end

  assign crc_bad = ({crc_hi_q, sd.sd_data} != crc_calc);
`else
  assign crc_bad = 1'b0;
`endif

  assign sd.sd_address = addr_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign rd_last       = rd_last_q;
  assign err_code      = err_code_q;
  assign r1_status     = r1_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader: directed bench for sd_block_reader. Two instances share
// stimulus: dut0 uses block addressing, dut1 byte addressing.
module tb_sd_block_reader;
  import sd_block_reader_pkg::*;

  localparam int BLOCK_BYTES = 512;
  localparam int TIMEOUT     = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [31:0] req_lba = '0;
  logic        sd_rdy = 1'b0;
  logic        sd_valid_status = 1'b0;
  logic [6:0]  sd_resp_status = '0;
  logic [7:0]  sd_data = '0;
  logic        sd_data_valid = 1'b0;

  sd_block_reader_if bus0();
  sd_block_reader_if bus1();
  assign bus0.sd_rdy = sd_rdy;           assign bus1.sd_rdy = sd_rdy;
  assign bus0.sd_valid_status = sd_valid_status; assign bus1.sd_valid_status = sd_valid_status;
  assign bus0.sd_resp_status = sd_resp_status;   assign bus1.sd_resp_status = sd_resp_status;
  assign bus0.sd_data = sd_data;         assign bus1.sd_data = sd_data;
  assign bus0.sd_data_valid = sd_data_valid;     assign bus1.sd_data_valid = sd_data_valid;

  logic       req_ready0, rd_valid0, rd_last0, busy0, done0, err0;
  logic [7:0] rd_data0;
  logic [1:0] err_code0;
  logic [6:0] r1_status0;
  state_t     dbg_state0;
  logic       req_ready1, rd_valid1, rd_last1, busy1, done1, err1;
  logic [7:0] rd_data1;
  logic [1:0] err_code1;
  logic [6:0] r1_status1;
  state_t     dbg_state1;

  sd_block_reader #(.BLOCK_BYTES(BLOCK_BYTES), .TIMEOUT_CYCLES(TIMEOUT), .BYTE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lba(req_lba), .req_ready(req_ready0),
    .sd(bus0.master), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_last(rd_last0),
    .busy(busy0), .done(done0), .err(err0), .err_code(err_code0), .r1_status(r1_status0),
    .dbg_state(dbg_state0));

  sd_block_reader #(.BLOCK_BYTES(BLOCK_BYTES), .TIMEOUT_CYCLES(TIMEOUT), .BYTE_ADDR(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lba(req_lba), .req_ready(req_ready1),
    .sd(bus1.master), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_last(rd_last1),
    .busy(busy1), .done(done1), .err(err1), .err_code(err_code1), .r1_status(r1_status1),
    .dbg_state(dbg_state1));

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0]  exp_q[$];          // {last, data} in stream order
  logic [7:0]  mbuf [0:1023];     // message bytes for the CRC model
  logic [31:0] exp_addr0 = '0;
  logic [31:0] exp_addr1 = '0;
  logic [6:0]  exp_r1 = '0;
  int n_rd = 0, n_last = 0, n_en0 = 0, n_en1 = 0, n_done = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // CRC16-CCITT as the remainder of M(x)*x^16 divided by the generator
  function automatic logic [15:0] crc_of(input int n);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < n * 8 + 16; i++) begin
      b   = (i < n * 8) ? mbuf[i / 8][7 - (i % 8)] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  // Compare process: stream bytes, command strobes, done qualifiers
  always @(negedge clk) begin
    if (rst) begin
      if (rd_valid0) begin
        n_rd++;
        if (rd_last0) n_last++;
        if (exp_q.size() == 0) check("rd_valid_unexpected", {31'b0, rd_valid0}, 32'd0);
        else check("rd_byte", {23'b0, rd_last0, rd_data0}, {23'b0, exp_q.pop_front()});
      end
      if (bus0.sd_en) begin
        n_en0++;
        check("sd_cmd", {25'b0, bus0.sd_cmd}, 32'd17);
        check("sd_address_blk", bus0.sd_address, exp_addr0);
      end
      if (bus1.sd_en) begin
        n_en1++;
        check("sd_address_byte", bus1.sd_address, exp_addr1);
      end
      if (done0) begin
        n_done++;
        check("busy_at_done", {31'b0, busy0}, 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] lba, input logic [31:0] addr_byte, input bit hold);
    int n;
    n = 0;
    exp_addr0 = lba;
    exp_addr1 = addr_byte;
    req_lba   = lba;
    req_valid = 1'b1;
    while (!req_ready0 && n < 50) begin
      step();
      n++;
    end
    check("req_ready_wait", {31'b0, req_ready0}, 32'd1);
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic send_r1(input logic [6:0] v);
    step();
    sd_valid_status = 1'b1;
    sd_resp_status  = v;
    step();
    sd_valid_status = 1'b0;
    exp_r1 = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    sd_data       = b;
    sd_data_valid = 1'b1;
    step();
    sd_data_valid = 1'b0;
    repeat (gap) step();
  endtask

  // zero_data=0: bytes 0..255,0..255; zero_data=1: all zero
  task automatic send_block(input bit zero_data);
    logic [7:0] b;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      b = zero_data ? 8'h00 : 8'(i % 256);
      mbuf[i] = b;
      exp_q.push_back({(i == BLOCK_BYTES - 1), b});
      send_byte(b, (i % 5 == 0) ? 1 : 0);
    end
  endtask

  task automatic finish_txn(input string tag, input int max, input logic exp_err,
                            input logic [1:0] exp_code, output int cyc);
    logic got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= max) begin
      if (done0) got = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    check({tag, "_done"}, {31'b0, got}, 32'd1);
    if (got) begin
      check({tag, "_err"}, {31'b0, err0}, {31'b0, exp_err});
      check({tag, "_code"}, {30'b0, err_code0}, {30'b0, exp_code});
      check({tag, "_r1"}, {25'b0, r1_status0}, {25'b0, exp_r1});
      check({tag, "_dut1_done"}, {31'b0, done1}, 32'd1);
    end
    step();
    check({tag, "_busy_clear"}, {31'b0, busy0}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int rd_before, en_before, done_before;
    logic [15:0] crc;
    logic [1:0]  crc_code;

    // Reset state
    #1;
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready0}, 32'd0);
    check("rst_sd_en", {31'b0, bus0.sd_en}, 32'd0);
    check("rst_sd_cmd", {25'b0, bus0.sd_cmd}, 32'd0);
    check("rst_sd_address", bus0.sd_address, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid0}, 32'd0);
    check("rst_err_code", {30'b0, err_code0}, 32'd0);
    check("rst_state", {29'b0, dbg_state0}, {29'b0, ST_IDLE});
    repeat (3) step();
    rst = 1'b1;
    step();
    check("ready_without_sd_rdy", {31'b0, req_ready0}, 32'd0);
    sd_rdy = 1'b1;
    #1;
    check("ready_with_sd_rdy", {31'b0, req_ready0}, 32'd1);
    step();

    // Model pin: CRC16-CCITT(init 0) of "123456789" is 0x31C3
    for (int i = 0; i < 9; i++) mbuf[i] = 8'h31 + 8'(i);
    check("crc_model_pin", {16'b0, crc_of(9)}, 32'h31C3);

    // Full block, lba 0x10
    send_req(32'h10, 32'h2000, 1'b0);
    send_r1(7'h00);
    repeat (3) send_byte(TOKEN_IDLE, 0);
    send_byte(TOKEN_START, 1);
    send_block(1'b0);
    crc = crc_of(BLOCK_BYTES);
    send_byte(crc[15:8], 0);
    send_byte(crc[7:0], 0);
    finish_txn("block", 40, 1'b0, ERR_NONE, cyc);
    check("block_rd_count", n_rd, 32'd512);
    check("block_last_count", n_last, 32'd1);
    check("block_queue_empty", exp_q.size(), 32'd0);
    check("block_en_pulses", n_en0, 32'd1);

    // Byte addressing 3 -> 0x600, R1 error
    rd_before = n_rd;
    send_req(32'h3, 32'h600, 1'b0);
    send_r1(7'h04);
    finish_txn("r1err", 40, 1'b1, ERR_R1, cyc);
    check("r1err_no_rd", n_rd, rd_before);
    check("r1err_en_pulses_byte", n_en1, 32'd2);

    // Bad token after FF filler; byte address shift truncates to 32 bits
    send_req(32'h00FF_FFFF, 32'hFFFF_FE00, 1'b0);
    send_r1(7'h00);
    send_byte(TOKEN_IDLE, 0);
    send_byte(8'h05, 0);
    finish_txn("badtok", 40, 1'b1, ERR_TOKEN, cyc);

    // Token timeout: done TIMEOUT cycles after R1 is taken
    send_req(32'h7, 32'hE00, 1'b0);
    send_r1(7'h00);
    finish_txn("tok_to", 200, 1'b1, ERR_TOKEN, cyc);
    check("tok_to_cycles", cyc, TIMEOUT);

    // R1 timeout: one issue cycle, then TIMEOUT cycles of waiting
    send_req(32'h8, 32'h1000, 1'b0);
    finish_txn("r1_to", 200, 1'b1, ERR_TOKEN, cyc);
    check("r1_to_cycles", cyc, TIMEOUT + 1);

    // All-zero block, matching CRC 0x0000
    send_req(32'h9, 32'h1200, 1'b0);
    send_r1(7'h00);
    send_byte(TOKEN_START, 0);
    send_block(1'b1);
    check("zero_crc_model", {16'b0, crc_of(BLOCK_BYTES)}, 32'h0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    finish_txn("crc_ok", 40, 1'b0, ERR_NONE, cyc);

    // All-zero block, wrong CRC 0x1234
`ifdef SD_BLOCK_CRC_EN
    crc_code = (crc_of(BLOCK_BYTES) != 16'h1234) ? ERR_CRC : ERR_NONE;
`else
    crc_code = ERR_NONE;
`endif
    send_req(32'hA, 32'h1400, 1'b0);
    send_r1(7'h00);
    send_byte(TOKEN_START, 0);
    send_block(1'b1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    finish_txn("crc_bad", 40, (crc_code != ERR_NONE), crc_code, cyc);
    check("crc_bad_queue_empty", exp_q.size(), 32'd0);

    // Reset at data byte 200 with req_valid held high throughout
    en_before = n_en0;
    send_req(32'h40, 32'h8000, 1'b1);
    send_r1(7'h00);
    send_byte(TOKEN_START, 0);
    for (int i = 0; i < 200; i++) begin
      mbuf[i] = 8'(i);
      exp_q.push_back({1'b0, 8'(i)});
      send_byte(8'(i), (i % 5 == 0) ? 1 : 0);
    end
    step();
    check("held_req_not_reaccepted", n_en0, en_before + 1);
    done_before   = n_done;
    sd_data       = 8'd200;
    sd_data_valid = 1'b1;
    rst           = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy0}, 32'd0);
    check("abort_rd_valid", {31'b0, rd_valid0}, 32'd0);
    check("abort_sd_cmd", {25'b0, bus0.sd_cmd}, 32'd0);
    check("abort_r1", {25'b0, r1_status0}, 32'd0);
    check("abort_queue_empty", exp_q.size(), 32'd0);
    sd_data_valid = 1'b0;
    exp_r1 = '0;
    repeat (3) step();
    check("abort_no_done", n_done, done_before);
    rst = 1'b1;
    cyc = 0;
    while (!bus0.sd_en && cyc < 10) begin
      step();
      cyc++;
    end
    check("reaccept_after_idle", {31'b0, bus0.sd_en}, 32'd1);
    req_valid = 1'b0;
    send_r1(7'h04);
    finish_txn("after_abort", 40, 1'b1, ERR_R1, cyc);
    check("after_abort_en_pulses", n_en0, en_before + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
